// File: rtl/stage_if_pkg.sv
// stage_if_pkg: shared fetch-stage types and constants
package stage_if_pkg;
  typedef enum logic {IF_FETCH, IF_DONE} if_state_t;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NON_OP = 32'h0000_0000;
  localparam int INST_BYTES = 4;
  localparam int STALL_W = 6;
endpackage

// File: rtl/stage_if.sv
// stage_if: RV32I fetch stage assembling little-endian words over an 8-bit memory port
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [5:0]  stall,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        if_stall_req_o
);
  if_state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, asm, asm_n, asm_ack, word, mem_addr_n;
  logic [1:0] byte_cnt, byte_cnt_n;
  logic mem_req_n, take, out_free, load;
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};
  assign take = mem_req_o && mem_ack_i;
  assign out_free = !inst_valid_o || !stall[1];
  assign if_stall_req_o = !inst_valid_o && !rst;
  always_comb begin
    asm_ack = asm;
    asm_ack[{byte_cnt, 3'b000} +: 8] = mem_data_i;
    word = (state == IF_DONE) ? asm : asm_ack;
    state_n = state;
    fetch_pc_n = fetch_pc;
    byte_cnt_n = byte_cnt;
    asm_n = asm;
    mem_req_n = 1'b1;
    mem_addr_n = fetch_pc + {30'b0, byte_cnt};
    load = 1'b0;
    if (branch_enable_i) begin
      state_n = IF_FETCH;
      fetch_pc_n = branch_addr_i;
      byte_cnt_n = 2'd0;
      asm_n = ZERO_WORD;
      mem_req_n = 1'b0;
      mem_addr_n = branch_addr_i;
    end else if (state == IF_DONE || (take && byte_cnt == 2'd3)) begin
      load = out_free;
      asm_n = word;
      byte_cnt_n = 2'd0;
      state_n = out_free ? IF_FETCH : IF_DONE;
      fetch_pc_n = out_free ? fetch_pc + 32'd4 : fetch_pc;
      mem_req_n = out_free;
      mem_addr_n = out_free ? fetch_pc + 32'd4 : mem_addr_o;
    end else if (take) begin
      asm_n = asm_ack;
      byte_cnt_n = byte_cnt + 2'd1;
      mem_addr_n = fetch_pc + {30'b0, byte_cnt + 2'd1};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_FETCH;
      fetch_pc <= RESET_PC;
      byte_cnt <= 2'd0;
      asm <= ZERO_WORD;
      mem_req_o <= 1'b0;
      mem_addr_o <= RESET_PC;
    end else if (rdy) begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      byte_cnt <= byte_cnt_n;
      asm <= asm_n;
      mem_req_o <= mem_req_n;
      mem_addr_o <= mem_addr_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= ZERO_WORD;
      inst_o <= NON_OP;
      inst_valid_o <= 1'b0;
    end else if (rdy) begin
      if (load) begin
        pc_o <= fetch_pc;
        inst_o <= word;
        inst_valid_o <= 1'b1;
      end else if (branch_enable_i || !stall[1]) begin
        inst_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed vector table plus multi-cycle sequences for stage_if
module tb_stage_if;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, br = 1'b0, auto = 1'b0;
  logic rst2 = 1'b1;
  logic [5:0] stall = 6'b0;
  logic [31:0] ba = 32'h0;
  logic tab_ack = 1'b0, auto_ack = 1'b0, ack;
  logic [7:0] tab_d = 8'h00, auto_d = 8'h00, d;
  logic req, v, sreq;
  logic [31:0] addr, pc, inst;
  logic ack2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic req2, v2, sreq2;
  logic [31:0] addr2, pc2, inst2;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign ack = auto ? auto_ack : tab_ack;
  assign d = auto ? auto_d : tab_d;
  stage_if dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .branch_enable_i(br), .branch_addr_i(ba),
    .mem_req_o(req), .mem_addr_o(addr), .mem_ack_i(ack), .mem_data_i(d),
    .pc_o(pc), .inst_o(inst), .inst_valid_o(v), .if_stall_req_o(sreq)
  );
  stage_if #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .rdy(rdy), .stall(stall), .branch_enable_i(br), .branch_addr_i(ba),
    .mem_req_o(req2), .mem_addr_o(addr2), .mem_ack_i(ack2), .mem_data_i(d2),
    .pc_o(pc2), .inst_o(inst2), .inst_valid_o(v2), .if_stall_req_o(sreq2)
  );
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return (a[31:2] == 30'd0) ? ((a[1:0] == 2'd0) ? 8'h13 : 8'h00) : (a[7:0] ^ 8'hA5);
  endfunction
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction
  initial forever begin
    @(negedge clk);
    auto_ack = req;
    auto_d = byte_at(addr);
    ack2 = req2;
    d2 = byte_at(addr2);
  end
  typedef struct {
    logic [3:0] ctl;
    logic [31:0] ba;
    logic ack;
    logic [7:0] d;
    logic e_req;
    logic [31:0] e_addr;
    logic e_v;
    logic [31:0] e_pc, e_inst;
  } vec_t;
  localparam int NV = 21;
  vec_t vt[NV];
  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] b, input logic k, input logic [7:0] x,
                              input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep, ei);
    vec_t r;
    r.ctl = c; r.ba = b; r.ack = k; r.d = x;
    r.e_req = er; r.e_addr = ea; r.e_v = ev; r.e_pc = ep; r.e_inst = ei;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passed++;
  endtask
  task automatic chk1(input string n, input logic act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", n, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string n);
    int k = 0;
    while (!v && k < 40) begin tick(); k++; end
    chk1(n, v, 1'b1);
  endtask
  task automatic wait_valid2(input string n);
    int k = 0;
    while (!v2 && k < 40) begin tick(); k++; end
    chk1(n, v2, 1'b1);
  endtask
  initial begin
    // ctl = {rst, rdy, stall[1], branch}
    vt[0]  = mk(4'b1100, 32'h0,   1'b0, 8'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    vt[1]  = mk(4'b1100, 32'h0,   1'b0, 8'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
    vt[2]  = mk(4'b0100, 32'h0,   1'b0, 8'h00, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
    vt[3]  = mk(4'b0100, 32'h0,   1'b1, 8'h13, 1'b1, 32'h1,   1'b0, 32'h0,   32'h0);
    vt[4]  = mk(4'b0100, 32'h0,   1'b1, 8'h00, 1'b1, 32'h2,   1'b0, 32'h0,   32'h0);
    vt[5]  = mk(4'b0100, 32'h0,   1'b1, 8'h00, 1'b1, 32'h3,   1'b0, 32'h0,   32'h0);
    vt[6]  = mk(4'b0100, 32'h0,   1'b1, 8'h00, 1'b1, 32'h4,   1'b1, 32'h0,   32'h13);
    vt[7]  = mk(4'b0100, 32'h0,   1'b0, 8'h00, 1'b1, 32'h4,   1'b0, 32'h0,   32'h13);
    vt[8]  = mk(4'b0100, 32'h0,   1'b1, 8'hAA, 1'b1, 32'h5,   1'b0, 32'h0,   32'h13);
    vt[9]  = mk(4'b0100, 32'h0,   1'b1, 8'hBB, 1'b1, 32'h6,   1'b0, 32'h0,   32'h13);
    vt[10] = mk(4'b0101, 32'h100, 1'b1, 8'hCC, 1'b0, 32'h100, 1'b0, 32'h0,   32'h13);
    vt[11] = mk(4'b0100, 32'h0,   1'b0, 8'h00, 1'b1, 32'h100, 1'b0, 32'h0,   32'h13);
    vt[12] = mk(4'b0100, 32'h0,   1'b1, 8'h93, 1'b1, 32'h101, 1'b0, 32'h0,   32'h13);
    vt[13] = mk(4'b0100, 32'h0,   1'b1, 8'h00, 1'b1, 32'h102, 1'b0, 32'h0,   32'h13);
    vt[14] = mk(4'b0100, 32'h0,   1'b1, 8'h50, 1'b1, 32'h103, 1'b0, 32'h0,   32'h13);
    vt[15] = mk(4'b0100, 32'h0,   1'b1, 8'h01, 1'b1, 32'h104, 1'b1, 32'h100, 32'h01500093);
    vt[16] = mk(4'b0110, 32'h0,   1'b0, 8'h00, 1'b1, 32'h104, 1'b1, 32'h100, 32'h01500093);
    vt[17] = mk(4'b0111, 32'h200, 1'b0, 8'h00, 1'b0, 32'h200, 1'b0, 32'h100, 32'h01500093);
    vt[18] = mk(4'b0100, 32'h0,   1'b0, 8'h00, 1'b1, 32'h200, 1'b0, 32'h100, 32'h01500093);
    vt[19] = mk(4'b0000, 32'h0,   1'b1, 8'h77, 1'b1, 32'h200, 1'b0, 32'h100, 32'h01500093);
    vt[20] = mk(4'b0100, 32'h0,   1'b1, 8'h11, 1'b1, 32'h201, 1'b0, 32'h100, 32'h01500093);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      {rst, rdy, stall[1], br} = vt[i].ctl;
      ba = vt[i].ba;
      tab_ack = vt[i].ack;
      tab_d = vt[i].d;
      tick();
      chk1($sformatf("v%0d req", i), req, vt[i].e_req);
      chk($sformatf("v%0d addr", i), addr, vt[i].e_addr);
      chk1($sformatf("v%0d valid", i), v, vt[i].e_v);
      chk($sformatf("v%0d pc", i), pc, vt[i].e_pc);
      chk($sformatf("v%0d inst", i), inst, vt[i].e_inst);
      chk1($sformatf("v%0d stall_req", i), sreq, !vt[i].ctl[3] && !vt[i].e_v);
    end
    @(negedge clk);
    {rst, rdy, stall[1], br} = 4'b1100;
    tab_ack = 1'b0;
    auto = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_valid("stl first valid");
    chk("stl pc0", pc, 32'h0);
    chk("stl inst0", inst, 32'h13);
    stall[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("stl hold valid", v, 1'b1);
      chk("stl hold pc", pc, 32'h0);
    end
    chk1("stl done req low", req, 1'b0);
    stall[1] = 1'b0;
    tick();
    chk1("stl release valid", v, 1'b1);
    chk("stl release pc", pc, 32'h4);
    chk("stl release inst", inst, word_at(32'h4));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    begin
      int k = 0;
      while (addr !== 32'h2 && k < 40) begin tick(); k++; end
      chk("rdy reach addr2", addr, 32'h2);
    end
    rdy = 1'b0;
    auto = 1'b0;
    tab_ack = 1'b1;
    tab_d = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("rdy0 req", req, 1'b1);
      chk("rdy0 addr", addr, 32'h2);
      chk1("rdy0 valid", v, 1'b0);
      tab_ack = ~tab_ack;
    end
    rdy = 1'b1;
    auto = 1'b1;
    wait_valid("rdy resume valid");
    chk("rdy resume pc", pc, 32'h0);
    chk("rdy resume inst", inst, 32'h13);
    chk1("rpc in reset stall_req", sreq2, 1'b0);
    rst2 = 1'b0;
    wait_valid2("rpc first valid");
    chk("rpc pc", pc2, 32'hFFFF_FFFC);
    chk("rpc inst", inst2, word_at(32'hFFFF_FFFC));
    chk("rpc wrap addr", addr2, 32'h0);
    tick();
    tick();
    chk("rpc mid addr", addr2, 32'h2);
    rst2 = 1'b1;
    tick();
    chk1("rpc rst valid", v2, 1'b0);
    chk1("rpc rst req", req2, 1'b0);
    chk("rpc rst addr", addr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    wait_valid2("rpc restart valid");
    chk("rpc restart pc", pc2, 32'hFFFF_FFFC);
    chk("rpc restart inst", inst2, word_at(32'hFFFF_FFFC));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
